// File: rtl/riscv_pkg.sv
// Shared pipeline types: data width, forwarding select encoding, hazard FSM states
// and the forwarding priority function.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // The younger result (MEM) wins over WB, and x0 is never a forwarding source.
  function automatic fwd_sel_e fwd_pick(
    input logic       mem_wen,
    input logic [4:0] mem_rd,
    input logic       wb_wen,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    if (mem_wen && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection and operand forwarding selection.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rs1_addr_i,
  input  logic [4:0] ex_rs2_addr_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_wrt_ena_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] mem_rd_addr_i,
  input  logic       mem_rd_wrt_ena_i,
  input  logic [4:0] wb_rd_addr_i,
  input  logic       wb_rd_wrt_ena_i,
  output logic       load_use_o,
  output fwd_sel_e   fwd_rs1_sel_o,
  output fwd_sel_e   fwd_rs2_sel_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);

  assign load_use_o = ex_is_load_i && ex_rd_wrt_ena_i && (ex_rd_addr_i != 5'd0)
                      && (rs1_hit || rs2_hit);

  assign fwd_rs1_sel_o = fwd_pick(mem_rd_wrt_ena_i, mem_rd_addr_i,
                                  wb_rd_wrt_ena_i, wb_rd_addr_i, ex_rs1_addr_i);
  assign fwd_rs2_sel_o = fwd_pick(mem_rd_wrt_ena_i, mem_rd_addr_i,
                                  wb_rd_wrt_ena_i, wb_rd_addr_i, ex_rs2_addr_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect FSM, redirect capture while the
// memory is stalled, forwarding selects and stall/flush performance counters.
module hazard_ctrl
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [4:0]      ex_rs1_addr_i,
  input  logic [4:0]      ex_rs2_addr_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rd_wrt_ena_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_wrt_ena_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_rd_wrt_ena_i,
  input  logic            next_pc_ena_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            ext_stall_i,
  output logic            if_stall_o,
  output logic            id_stall_o,
  output logic            id_flush_o,
  output logic            ex_flush_o,
  output fwd_sel_e        fwd_rs1_sel_o,
  output fwd_sel_e        fwd_rs2_sel_o,
  output logic            pc_redirect_ena_o,
  output logic [XLEN-1:0] pc_redirect_o,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
);

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [31:0]     stall_cnt_q, flush_cnt_q;

  logic            load_use;
  fwd_sel_e        fwd1_raw;
  fwd_sel_e        fwd2_raw;

  hazard_detect u_detect (
    .id_rs1_addr_i    (id_rs1_addr_i),
    .id_rs2_addr_i    (id_rs2_addr_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .ex_rs1_addr_i    (ex_rs1_addr_i),
    .ex_rs2_addr_i    (ex_rs2_addr_i),
    .ex_rd_addr_i     (ex_rd_addr_i),
    .ex_rd_wrt_ena_i  (ex_rd_wrt_ena_i),
    .ex_is_load_i     (ex_is_load_i),
    .mem_rd_addr_i    (mem_rd_addr_i),
    .mem_rd_wrt_ena_i (mem_rd_wrt_ena_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .wb_rd_wrt_ena_i  (wb_rd_wrt_ena_i),
    .load_use_o       (load_use),
    .fwd_rs1_sel_o    (fwd1_raw),
    .fwd_rs2_sel_o    (fwd2_raw)
  );

  assign fwd_rs1_sel_o = rst_i ? FWD_NONE : fwd1_raw;
  assign fwd_rs2_sel_o = rst_i ? FWD_NONE : fwd2_raw;

  always_comb begin
    state_d           = state_q;
    pend_d            = pend_q;
    tgt_d             = tgt_q;
    if_stall_o        = 1'b0;
    id_stall_o        = 1'b0;
    id_flush_o        = 1'b0;
    ex_flush_o        = 1'b0;
    pc_redirect_ena_o = 1'b0;
    pc_redirect_o     = '0;

    if (rst_i) begin
      state_d = RUN;
    end else if (ext_stall_i) begin
      if_stall_o = 1'b1;
      id_stall_o = 1'b1;
      state_d    = HOLD;
      if (next_pc_ena_i && !pend_q) begin
        pend_d = 1'b1;
        tgt_d  = next_pc_i;
      end
    end else begin
      case (state_q)
        RUN, HOLD: begin
          if (pend_q) begin
            // A redirect captured during the stall is issued on the first free cycle.
            pc_redirect_ena_o = 1'b1;
            pc_redirect_o     = tgt_q;
            id_flush_o        = 1'b1;
            ex_flush_o        = 1'b1;
            pend_d            = 1'b0;
            tgt_d             = '0;
            state_d           = FLUSH;
          end else if (state_q == HOLD) begin
            state_d = RUN;
          end else if (next_pc_ena_i) begin
            pc_redirect_ena_o = 1'b1;
            pc_redirect_o     = next_pc_i;
            id_flush_o        = 1'b1;
            ex_flush_o        = 1'b1;
            state_d           = FLUSH;
          end else if (load_use) begin
            if_stall_o = 1'b1;
            id_stall_o = 1'b1;
            ex_flush_o = 1'b1;
          end
        end
        FLUSH: begin
          id_flush_o = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_q + {31'd0, if_stall_o};
      flush_cnt_q <= flush_cnt_q + {31'd0, (id_flush_o | ex_flush_o)};
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expected outputs queued at drive time,
// popped and compared before the edge; counters tracked and compared after it.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [4:0]      id_rs1_addr_i, id_rs2_addr_i;
  logic            id_rs1_used_i, id_rs2_used_i;
  logic [4:0]      ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
  logic            ex_rd_wrt_ena_i, ex_is_load_i;
  logic [4:0]      mem_rd_addr_i, wb_rd_addr_i;
  logic            mem_rd_wrt_ena_i, wb_rd_wrt_ena_i;
  logic            next_pc_ena_i;
  logic [XLEN-1:0] next_pc_i;
  logic            ext_stall_i;
  logic            if_stall_o, id_stall_o, id_flush_o, ex_flush_o;
  fwd_sel_e        fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic            pc_redirect_ena_o;
  logic [XLEN-1:0] pc_redirect_o;
  logic [31:0]     stall_cnt_o, flush_cnt_o;

  hazard_ctrl dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .ex_rs1_addr_i     (ex_rs1_addr_i),
    .ex_rs2_addr_i     (ex_rs2_addr_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_rd_wrt_ena_i   (ex_rd_wrt_ena_i),
    .ex_is_load_i      (ex_is_load_i),
    .mem_rd_addr_i     (mem_rd_addr_i),
    .mem_rd_wrt_ena_i  (mem_rd_wrt_ena_i),
    .wb_rd_addr_i      (wb_rd_addr_i),
    .wb_rd_wrt_ena_i   (wb_rd_wrt_ena_i),
    .next_pc_ena_i     (next_pc_ena_i),
    .next_pc_i         (next_pc_i),
    .ext_stall_i       (ext_stall_i),
    .if_stall_o        (if_stall_o),
    .id_stall_o        (id_stall_o),
    .id_flush_o        (id_flush_o),
    .ex_flush_o        (ex_flush_o),
    .fwd_rs1_sel_o     (fwd_rs1_sel_o),
    .fwd_rs2_sel_o     (fwd_rs2_sel_o),
    .pc_redirect_ena_o (pc_redirect_ena_o),
    .pc_redirect_o     (pc_redirect_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic        ifs, ids, idf, exf, rde;
    logic [31:0] rd;
    logic [1:0]  f1, f2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] stall_m = 0;
  logic [31:0] flush_m = 0;

  function automatic exp_t mk(input string tag, input logic ifs, input logic ids,
                              input logic idf, input logic exf, input logic rde,
                              input logic [31:0] rd, input logic [1:0] f1,
                              input logic [1:0] f2);
    exp_t e;
    e.tag = tag; e.ifs = ifs; e.ids = ids; e.idf = idf; e.exf = exf;
    e.rde = rde; e.rd = rd; e.f1 = f1; e.f2 = f2;
    return e;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got %0h expected %0h", tag, name, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
    ex_rs1_addr_i = 0; ex_rs2_addr_i = 0; ex_rd_addr_i = 0;
    ex_rd_wrt_ena_i = 0; ex_is_load_i = 0;
    mem_rd_addr_i = 0; mem_rd_wrt_ena_i = 0; wb_rd_addr_i = 0; wb_rd_wrt_ena_i = 0;
    next_pc_ena_i = 0; next_pc_i = 0; ext_stall_i = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load_i = 1; ex_rd_wrt_ena_i = 1; ex_rd_addr_i = rd;
    id_rs1_addr_i = rd; id_rs1_used_i = 1;
  endtask

  // Called at the falling edge after inputs are driven; returns at the next falling edge.
  task automatic step(input exp_t e);
    exp_t c;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      chk(e.tag, "sb_empty", 32'd1, 32'd0);
    end else begin
      c = sb.pop_front();
      chk(c.tag, "if_stall", {31'd0, if_stall_o}, {31'd0, c.ifs});
      chk(c.tag, "id_stall", {31'd0, id_stall_o}, {31'd0, c.ids});
      chk(c.tag, "id_flush", {31'd0, id_flush_o}, {31'd0, c.idf});
      chk(c.tag, "ex_flush", {31'd0, ex_flush_o}, {31'd0, c.exf});
      chk(c.tag, "redir_ena", {31'd0, pc_redirect_ena_o}, {31'd0, c.rde});
      chk(c.tag, "redir_pc", pc_redirect_o, c.rd);
      chk(c.tag, "fwd1", {30'd0, fwd_rs1_sel_o}, {30'd0, c.f1});
      chk(c.tag, "fwd2", {30'd0, fwd_rs2_sel_o}, {30'd0, c.f2});
    end
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      stall_m = 0;
      flush_m = 0;
    end else begin
      stall_m = stall_m + {31'd0, e.ifs};
      flush_m = flush_m + {31'd0, (e.idf | e.exf)};
    end
    chk(e.tag, "stall_cnt", stall_cnt_o, stall_m);
    chk(e.tag, "flush_cnt", flush_cnt_o, flush_m);
    $display("step %-10s stall_cnt=%0d flush_cnt=%0d", e.tag, stall_cnt_o, flush_cnt_o);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_i = 1;
    @(negedge clk_i);

    // Reset with a stall and redirect present: nothing may be captured.
    ext_stall_i = 1; next_pc_ena_i = 1; next_pc_i = 32'h999; set_load_use(5'd5);
    mem_rd_addr_i = 5'd3; mem_rd_wrt_ena_i = 1; ex_rs1_addr_i = 5'd3;
    step(mk("rst0", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    step(mk("rst1", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    idle(); rst_i = 0;
    step(mk("post_rst", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));

    set_load_use(5'd5);
    step(mk("load_use", 1, 1, 0, 1, 0, 0, FWD_NONE, FWD_NONE));
    idle();
    step(mk("lu_done", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));

    // Redirect with a simultaneous load-use: redirect wins.
    set_load_use(5'd6); next_pc_ena_i = 1; next_pc_i = 32'h100;
    step(mk("redir", 0, 0, 1, 1, 1, 32'h100, FWD_NONE, FWD_NONE));
    idle(); next_pc_ena_i = 1; next_pc_i = 32'h300;
    step(mk("flush", 0, 0, 1, 0, 0, 0, FWD_NONE, FWD_NONE));
    idle();
    step(mk("after_fl", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));

    // Stall for three cycles; the first redirect seen is the one kept.
    ext_stall_i = 1; next_pc_ena_i = 1; next_pc_i = 32'h200;
    step(mk("hold1", 1, 1, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    next_pc_i = 32'h400;
    step(mk("hold2", 1, 1, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    next_pc_ena_i = 0;
    step(mk("hold3", 1, 1, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    idle();
    step(mk("pend_iss", 0, 0, 1, 1, 1, 32'h200, FWD_NONE, FWD_NONE));
    step(mk("pend_fl", 0, 0, 1, 0, 0, 0, FWD_NONE, FWD_NONE));
    step(mk("pend_end", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));

    // Release from HOLD without a pending redirect is a quiet cycle.
    ext_stall_i = 1;
    step(mk("hold_np", 1, 1, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    idle(); set_load_use(5'd9);
    step(mk("hold_rel", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    step(mk("lu_run", 1, 1, 0, 1, 0, 0, FWD_NONE, FWD_NONE));
    idle();

    // Forwarding priority and x0 exclusion.
    mem_rd_addr_i = 5'd7; mem_rd_wrt_ena_i = 1; wb_rd_addr_i = 5'd7; wb_rd_wrt_ena_i = 1;
    ex_rs2_addr_i = 5'd7; ex_rs1_addr_i = 5'd3;
    step(mk("fwd_mem", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_MEM));
    mem_rd_addr_i = 5'd0;
    step(mk("fwd_wb", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_WB));
    mem_rd_addr_i = 5'd3; wb_rd_addr_i = 5'd2; wb_rd_wrt_ena_i = 0; ex_rs2_addr_i = 5'd2;
    step(mk("fwd_r1", 0, 0, 0, 0, 0, 0, FWD_MEM, FWD_NONE));
    idle();
    ex_is_load_i = 1; ex_rd_wrt_ena_i = 1; ex_rd_addr_i = 0; id_rs1_used_i = 1;
    mem_rd_wrt_ena_i = 1; wb_rd_wrt_ena_i = 1;
    step(mk("x0", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    idle();

    // Reset while holding with a pending redirect drops it.
    ext_stall_i = 1; next_pc_ena_i = 1; next_pc_i = 32'h500;
    step(mk("hold_pr", 1, 1, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    next_pc_ena_i = 0; rst_i = 1;
    step(mk("rst_hold", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    rst_i = 0; idle();
    step(mk("rst_rel", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));
    step(mk("rst_rel2", 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
